// File: rtl/mux_scan_nx1.sv
// Registered N-to-1 multiplexer: manual channel select, or a scan that holds each channel DWELL
// enabled cycles. Define MUX_SCAN_MASK_EN to add ch_mask_i, which removes channels from use.
module mux_scan_nx1 #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned DWELL    = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [WIDTH*CHANNELS-1:0] din_i,
    input  logic                      en_i,
    input  logic                      mode_i,
    input  logic [SEL_W-1:0]          sel_i,
`ifdef MUX_SCAN_MASK_EN
    input  logic [CHANNELS-1:0]       ch_mask_i,
`endif
    output logic [WIDTH-1:0]          out_o,
    output logic                      out_valid_o,
    output logic [SEL_W-1:0]          cur_sel_o,
    output logic                      wrap_o
);

    localparam int unsigned DwellW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {StIdle, StManual, StScan} state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [DwellW-1:0]   dwell_q, dwell_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic                valid_q, valid_d;
    logic [SEL_W-1:0]    cur_sel_q, cur_sel_d;
    logic                wrap_q, wrap_d;
    logic                pend_q, pend_d;

    logic [CHANNELS-1:0] mask;
    logic [WIDTH-1:0]    chan [CHANNELS];
    logic [SEL_W-1:0]    first_idx, nxt_idx, cand, scan_ptr;
    logic [DwellW-1:0]   scan_dwell;
    logic                nxt_found, all_masked, sel_ok;

`ifdef MUX_SCAN_MASK_EN
    assign mask = ch_mask_i;
`else
    assign mask = '0;
`endif

    assign all_masked = &mask;

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            chan[k] = din_i[k*WIDTH +: WIDTH];
        end
    end

    // A fresh scan starts at the lowest usable channel with an empty dwell count.
    always_comb begin
        first_idx = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (!mask[k]) begin
                first_idx = SEL_W'(k);
            end
        end
        scan_ptr   = (state_q == StScan) ? ptr_q : first_idx;
        scan_dwell = (state_q == StScan) ? dwell_q : '0;
    end

    // Next usable channel in ascending order, wrapping; falls back to scan_ptr if none.
    always_comb begin
        nxt_idx   = scan_ptr;
        nxt_found = 1'b0;
        cand      = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            cand = SEL_W'((32'(scan_ptr) + 32'(i)) % CHANNELS);
            if (!nxt_found && !mask[cand]) begin
                nxt_found = 1'b1;
                nxt_idx   = cand;
            end
        end
    end

    assign sel_ok = (32'(sel_i) < CHANNELS) && !mask[sel_i];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        dwell_d   = dwell_q;
        out_d     = out_q;
        cur_sel_d = cur_sel_q;
        valid_d   = 1'b0;
        wrap_d    = 1'b0;
        pend_d    = pend_q;
        if (en_i) begin
            if (!mode_i) begin
                state_d   = StManual;
                ptr_d     = '0;
                dwell_d   = '0;
                pend_d    = 1'b0;
                cur_sel_d = sel_i;
                out_d     = sel_ok ? chan[sel_i] : '0;
                valid_d   = sel_ok;
            end else begin
                state_d = StScan;
                pend_d  = 1'b0;
                if (all_masked) begin
                    out_d = '0;
                end else begin
                    out_d     = chan[scan_ptr];
                    cur_sel_d = scan_ptr;
                    valid_d   = 1'b1;
                    // The sweep-complete pulse lands alongside the first channel of the new sweep.
                    wrap_d    = pend_q;
                    if (32'(scan_dwell) == DWELL - 1) begin
                        dwell_d = '0;
                        ptr_d   = nxt_idx;
                        pend_d  = (nxt_idx <= scan_ptr);
                    end else begin
                        dwell_d = scan_dwell + 1'b1;
                        ptr_d   = scan_ptr;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            dwell_q   <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            cur_sel_q <= '0;
            wrap_q    <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            dwell_q   <= dwell_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            cur_sel_q <= cur_sel_d;
            wrap_q    <= wrap_d;
            pend_q    <= pend_d;
        end
    end

    assign out_o       = out_q;
    assign out_valid_o = valid_q;
    assign cur_sel_o   = cur_sel_q;
    assign wrap_o      = wrap_q;

endmodule
